muldiv_unit: RTL

- Parametrised iterative multiply/divide unit with HI/LO special registers.
- Serves MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO for the core; sits beside the ALU in the datapath.
- Next generation of the single-cycle special-register path: configurable data width and bits retired per cycle, a start/busy/done handshake, and defined corner-case results.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } muldiv_state_t;

  // Counter must hold the full iteration count WIDTH/BPC.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
    return $clog2(width / bpc) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring-subtract divide on an {hi, lo} pair.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, hi_i} + ({1'b0, m_i} & {(WIDTH + 1){lo_i[0]}});
    shl  = {hi_i, lo_i[WIDTH-1]};
    diff = shl - {1'b0, m_i};
    if (is_div_i) begin
      // Partial remainder stays below the divisor, so the MSB of diff is the borrow.
      if (!diff[WIDTH]) begin
        hi_o = diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shl[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and start/busy/done handshake.
// Optional early termination when MULDIV_EARLY_TERM_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  muldiv_op_t       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] hi_wdata_i,
  input  logic [WIDTH-1:0] lo_wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = cnt_width(WIDTH, BPC);

  muldiv_state_t    state_q;
  logic             is_div_q, neg_res_q, neg_rem_q, dz_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, wlo_q, m_q, hi_q, lo_q;

  logic             a_neg, b_neg, iter_last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] ch_hi [BPC+1];
  logic [WIDTH-1:0] ch_lo [BPC+1];

  always_comb begin
    a_neg = ~op_i[0] & a_i[WIDTH-1];
    b_neg = ~op_i[0] & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  assign ch_hi[0] = acc_q;
  assign ch_lo[0] = wlo_q;

  for (genvar i = 0; i < BPC; i++) begin : gen_step
    muldiv_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .is_div_i(is_div_q),
      .hi_i    (ch_hi[i]),
      .lo_i    (ch_lo[i]),
      .m_i     (m_q),
      .hi_o    (ch_hi[i+1]),
      .lo_o    (ch_lo[i+1])
    );
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  always_comb begin
    // Low bits of lo still holding unconsumed multiplier after this iteration.
    rem_mask  = ~({WIDTH{1'b1}} << ((32'(cnt_q) - 32'd1) * BPC));
    iter_last = (cnt_q == CW'(1)) || (!is_div_q && ((ch_lo[BPC] & rem_mask) == '0));
  end
`else
  assign iter_last = (cnt_q == CW'(1));
`endif

  logic [2*WIDTH-1:0] prod_sh, prod_fix;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    // Skipped iterations would only have shifted right; apply that shift here.
    prod_sh = {acc_q, wlo_q} >> (32'(cnt_q) * BPC);
`else
    prod_sh = {acc_q, wlo_q};
`endif
    prod_fix = neg_res_q ? -prod_sh : prod_sh;
    quo      = dz_q ? '1 : (neg_res_q ? -wlo_q : wlo_q);
    rem      = neg_rem_q ? -acc_q : acc_q;
    fix_hi   = is_div_q ? rem : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div_q ? quo : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wlo_q     <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (mthi_i) hi_q <= hi_wdata_i;
      if (mtlo_i) lo_q <= lo_wdata_i;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            is_div_q  <= op_i[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= op_i[1] && (b_i == '0);
            cnt_q     <= CW'(N);
            busy_q    <= 1'b1;
            acc_q     <= '0;
            wlo_q     <= op_i[1] ? a_mag : b_mag;
            m_q       <= op_i[1] ? b_mag : a_mag;
            state_q   <= StIter;
`ifdef MULDIV_EARLY_TERM_EN
            if (op_i[1] && (b_i == '0)) begin
              acc_q   <= a_mag;
              state_q <= StFix;
            end
`endif
          end
        end
        StIter: begin
          acc_q <= ch_hi[BPC];
          wlo_q <= ch_lo[BPC];
          cnt_q <= cnt_q - CW'(1);
          if (iter_last) state_q <= StFix;
        end
        StFix: begin
          // Result write lands after the MT writes above, so it takes priority.
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
